// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed 7-segment driver.
// Segment order is {a,b,c,d,e,f,g}, active low.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam int DIGITS_MIN   = 1;
    localparam int DIGITS_MAX   = 8;
    localparam int SCAN_DIV_MIN = 2;

    localparam seg_t HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic bit params_ok(
        input int digits,
        input int scan_div,
        input int gap
    );
        return (digits >= DIGITS_MIN) && (digits <= DIGITS_MAX) &&
               (scan_div >= SCAN_DIV_MIN) &&
               (gap >= 0) && (gap < scan_div);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: load/data side and display-pin side of the scan driver.
// master = datapath/bench, slave = the driver.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   data;
    logic [DIGITS-1:0]     dp_in;
    logic [6:0]            seg;
    logic                  dp;
    logic [DIGITS-1:0]     an;
    logic                  frame_tick;

    modport master (
        output load, data, dp_in,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  load, data, dp_in,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to active-low segment pattern.
// Shares the constant table with the rest of the display logic.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);
    always_comb begin
        seg = HEX_SEG[nibble];
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: scans DIGITS common-anode digits with a blank gap per slot.
// Define LZ_BLANK_EN to suppress leading-zero digits (digit 0 always shown).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GAP      = 16
) (
    input  logic clk,
    input  logic rst,
    seg7_scan_driver_if.slave bus
);
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (!params_ok(DIGITS, SCAN_DIV, GAP)) begin : g_bad_params
        $error("seg7_scan_driver: illegal DIGITS/SCAN_DIV/GAP");
    end

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] pend_data;
    logic [DIGITS-1:0]   pend_dp;
    logic                pend_v;
    logic [4*DIGITS-1:0] disp_data;
    logic [DIGITS-1:0]   disp_dp;

    logic [DIGITS-1:0]   an_q;
    seg_t                seg_q;
    logic                dp_q;
    logic                tick_q;

    logic                slot_end;
    logic                last_dig;
    logic                wrap;
    logic                lit;
    logic [3:0]          nib;
    seg_t                dec;
    logic                blank;
    logic [DIGITS-1:0]   an_next;
    seg_t                seg_next;

    assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
    assign last_dig = (idx == IDX_W'(DIGITS - 1));
    assign wrap     = slot_end && last_dig;
    assign lit      = int'(cnt) >= GAP;

    always_comb begin
        nib = disp_data[{idx, 2'b00} +: 4];
    end

    hex_to_seg7 u_dec (
        .nibble (nib),
        .seg    (dec)
    );

`ifdef LZ_BLANK_EN
    logic [DIGITS-1:0] lead_zero;

    // A digit blanks only if it and every more-significant nibble are zero.
    always_comb begin
        logic run;
        run       = 1'b1;
        lead_zero = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run          = run & (disp_data[4*i +: 4] == 4'h0);
            lead_zero[i] = run;
        end
    end

    assign blank = lead_zero[idx];
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        an_next  = '1;
        if (lit) begin
            an_next = ~(DIGITS'(1) << idx);
        end
        seg_next = blank ? SEG_BLANK : dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + CNT_W'(1);
            if (slot_end) begin
                idx <= last_dig ? '0 : idx + IDX_W'(1);
            end
        end
    end

    // Display data changes only at the frame wrap; a load that coincides
    // with the wrap bypasses the pending register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_v    <= 1'b0;
            disp_data <= '0;
            disp_dp   <= '0;
        end else if (wrap) begin
            if (bus.load) begin
                disp_data <= bus.data;
                disp_dp   <= bus.dp_in;
            end else if (pend_v) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
            end
            pend_v <= 1'b0;
        end else if (bus.load) begin
            pend_data <= bus.data;
            pend_dp   <= bus.dp_in;
            pend_v    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            an_q   <= an_next;
            seg_q  <= seg_next;
            dp_q   <= ~disp_dp[idx];
            tick_q <= wrap;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed scoreboard bench, DIGITS=4 SCAN_DIV=4 GAP=1.
// Expected digit slots are queued when loads are driven and popped per lit slot.
module tb_seg7_scan_driver;
    localparam int D = 4;

    localparam logic [6:0] DEC [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [11:0] sb [$];

    seg7_scan_driver_if #(.DIGITS(D)) bus ();

    seg7_scan_driver #(
        .DIGITS   (D),
        .SCAN_DIV (4),
        .GAP      (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void push_frame(input logic [15:0] d,
                                       input logic [3:0] p);
`ifdef LZ_BLANK_EN
        logic z;
        logic [3:0] lz;
        z  = 1'b1;
        lz = '0;
        for (int i = D - 1; i >= 1; i--) begin
            z     = z && (d[4*i +: 4] == 4'h0);
            lz[i] = z;
        end
`endif
        for (int i = 0; i < D; i++) begin
            logic [3:0] a;
            logic [6:0] s;
            a    = 4'b1111;
            a[i] = 1'b0;
            s    = DEC[d[4*i +: 4]];
`ifdef LZ_BLANK_EN
            if (lz[i]) s = 7'b1111111;
`endif
            sb.push_back({a, s, ~p[i]});
        end
    endfunction

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        bus.load  = 1'b1;
        bus.data  = d;
        bus.dp_in = p;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_tick !== 1'b1 && n < 40);
        chk({tag, "_tick_timeout"}, 32'(bus.frame_tick), 32'd1);
    endtask

    // Wait for the start of the next lit slot (gap -> lit transition).
    task automatic wait_lit(input string tag);
        logic [3:0] prev;
        logic found;
        int n;
        prev  = bus.an;
        found = 1'b0;
        n     = 0;
        while (!found && n < 20) begin
            @(negedge clk);
            n++;
            found = (bus.an !== 4'hf) && (bus.an !== prev);
            prev  = bus.an;
        end
        if (!found) chk({tag, "_lit_timeout"}, 32'(found), 32'd1);
    endtask

    task automatic next_lit(input string tag);
        logic [11:0] exp;
        wait_lit(tag);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            exp = sb.pop_front();
            chk(tag, {20'd0, bus.an, bus.seg, bus.dp}, {20'd0, exp});
        end
    endtask

    initial begin
        int n;
        bus.load  = 1'b0;
        bus.data  = '0;
        bus.dp_in = '0;

        repeat (3) @(negedge clk);
        chk("rst_an", 32'(bus.an), 32'hf);
        chk("rst_seg", 32'(bus.seg), 32'h7f);
        chk("rst_dp", 32'(bus.dp), 32'd1);
        chk("rst_tick", 32'(bus.frame_tick), 32'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("gap_an", 32'(bus.an), 32'hf);
        chk("gap_seg", 32'(bus.seg), 32'(7'b0000001));
        @(negedge clk);
        chk("first_an", 32'(bus.an), 32'he);
        chk("first_seg", 32'(bus.seg), 32'(7'b0000001));
        chk("first_dp", 32'(bus.dp), 32'd1);
        n = 2;
        do begin
            @(negedge clk);
            n++;
        end while (bus.frame_tick !== 1'b1 && n < 40);
        chk("tick_first", 32'(n), 32'd16);
        @(negedge clk);
        chk("tick_width", 32'(bus.frame_tick), 32'd0);
        n = 1;
        while (bus.frame_tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("tick_period", 32'(n), 32'd16);

        push_frame(16'h0000, 4'b0000);
        next_lit("old_d0");
        do_load(16'h1A3F, 4'b0100);
        next_lit("old_d1");
        next_lit("old_d2");
        next_lit("old_d3");
        push_frame(16'h1A3F, 4'b0100);
        for (int i = 0; i < D; i++) next_lit("new_1a3f");

        wait_tick("two_loads");
        push_frame(16'h1A3F, 4'b0100);
        next_lit("hold_d0");
        do_load(16'h1111, 4'b1111);
        next_lit("hold_d1");
        do_load(16'h2222, 4'b0011);
        next_lit("hold_d2");
        next_lit("hold_d3");
        push_frame(16'h2222, 4'b0011);
        for (int i = 0; i < D; i++) next_lit("last_wins");

        wait_tick("wrap_load");
        do_load(16'h1111, 4'b0000);
        repeat (14) @(negedge clk);
        bus.load  = 1'b1;
        bus.data  = 16'h00C5;
        bus.dp_in = 4'b0001;
        @(negedge clk);
        bus.load  = 1'b0;
        chk("wrap_tick", 32'(bus.frame_tick), 32'd1);
        push_frame(16'h00C5, 4'b0001);
        push_frame(16'h00C5, 4'b0001);
        for (int i = 0; i < 2 * D; i++) next_lit("wrap_00c5");

        wait_tick("mid_rst");
        wait_lit("mid_rst");
        wait_lit("mid_rst");
        do_load(16'h1234, 4'b1111);
        wait_lit("mid_rst");
        chk("pre_rst_an", 32'(bus.an), 32'hb);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_an", 32'(bus.an), 32'hf);
        chk("mrst_seg", 32'(bus.seg), 32'h7f);
        chk("mrst_dp", 32'(bus.dp), 32'd1);
        chk("mrst_tick", 32'(bus.frame_tick), 32'd0);
        rst = 1'b0;
        push_frame(16'h0000, 4'b0000);
        push_frame(16'h0000, 4'b0000);
        for (int i = 0; i < 2 * D; i++) next_lit("post_rst");

        wait_tick("lz5");
        do_load(16'h0005, 4'b0000);
        push_frame(16'h0005, 4'b0000);
        wait_tick("lz5");
        for (int i = 0; i < D; i++) next_lit("lz_0005");

        wait_tick("lz0");
        do_load(16'h0000, 4'b1010);
        push_frame(16'h0000, 4'b1010);
        wait_tick("lz0");
        for (int i = 0; i < D; i++) next_lit("lz_0000");

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
